// File: rtl/mem_block_arbiter.sv
// rtl/mem_block_arbiter.sv - serialises I-side and D-side block transfers onto one memory port
// Optional: ARB_ROUND_ROBIN_EN alternates I/D grants on ties; default is fixed D_WR > D_RD > I_RD.
module mem_block_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int BLK_W   = 256,
    parameter int TIMEOUT = 64
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              iBlkRead_IN,
    input  logic [ADDR_W-1:0] iBlkAddr_IN,
    output logic [BLK_W-1:0]  iBlkData_OUT,
    output logic              iBlkValid_OUT,
    input  logic              dBlkRead_IN,
    input  logic              dBlkWrite_IN,
    input  logic [ADDR_W-1:0] dBlkAddr_IN,
    input  logic [BLK_W-1:0]  dBlkWData_IN,
    output logic [BLK_W-1:0]  dBlkRData_OUT,
    output logic              dBlkValid_OUT,
    output logic [ADDR_W-1:0] blk_address_2M,
    output logic              blkRead_2M,
    output logic              blkWrite_2M,
    output logic [BLK_W-1:0]  block_write_2M,
    input  logic [BLK_W-1:0]  block_read_fM,
    input  logic              block_read_fM_valid,
    input  logic              block_write_fM_valid,
    output logic              Busy_OUT,
    output logic              Err_OUT
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] BLK_MASK = ~ADDR_W'(31);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        I_RD = 3'd1,
        D_RD = 3'd2,
        D_WR = 3'd3,
        RESP = 3'd4
    } state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [ADDR_W-1:0] addr_n;
    logic [BLK_W-1:0]  wdata_n, i_data_n, d_data_n;
    logic              cmd_rd_n, cmd_wr_n, i_vld_n, d_vld_n, err_n;
    logic              d_req, grant_d;

`ifdef ARB_ROUND_ROBIN_EN
    // Set when the D side was served last; reset value lets I win the first tie.
    logic last_d, last_d_n;
`endif

    assign d_req = dBlkRead_IN | dBlkWrite_IN;

`ifdef ARB_ROUND_ROBIN_EN
    assign grant_d = d_req & (~iBlkRead_IN | ~last_d);
`else
    assign grant_d = d_req;
`endif

    always_comb begin
        state_n  = state;
        cnt_n    = cnt + CNT_W'(1);
        addr_n   = blk_address_2M;
        wdata_n  = block_write_2M;
        i_data_n = iBlkData_OUT;
        d_data_n = dBlkRData_OUT;
        cmd_rd_n = blkRead_2M;
        cmd_wr_n = blkWrite_2M;
        i_vld_n  = 1'b0;
        d_vld_n  = 1'b0;
        err_n    = Err_OUT;
`ifdef ARB_ROUND_ROBIN_EN
        last_d_n = last_d;
`endif
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (grant_d) begin
                    addr_n = dBlkAddr_IN & BLK_MASK;
`ifdef ARB_ROUND_ROBIN_EN
                    last_d_n = 1'b1;
`endif
                    if (dBlkWrite_IN) begin
                        state_n  = D_WR;
                        cmd_wr_n = 1'b1;
                        wdata_n  = dBlkWData_IN;
                    end else begin
                        state_n  = D_RD;
                        cmd_rd_n = 1'b1;
                    end
                end else if (iBlkRead_IN) begin
                    state_n  = I_RD;
                    cmd_rd_n = 1'b1;
                    addr_n   = iBlkAddr_IN & BLK_MASK;
`ifdef ARB_ROUND_ROBIN_EN
                    last_d_n = 1'b0;
`endif
                end
            end
            I_RD, D_RD: begin
                // A valid arriving on the last allowed cycle still counts as success.
                if (block_read_fM_valid || cnt == CNT_LAST) begin
                    state_n  = RESP;
                    cmd_rd_n = 1'b0;
                    cnt_n    = '0;
                    if (!block_read_fM_valid)
                        err_n = 1'b1;
                    if (state == I_RD) begin
                        i_vld_n  = 1'b1;
                        i_data_n = block_read_fM_valid ? block_read_fM : '0;
                    end else begin
                        d_vld_n  = 1'b1;
                        d_data_n = block_read_fM_valid ? block_read_fM : '0;
                    end
                end
            end
            D_WR: begin
                if (block_write_fM_valid || cnt == CNT_LAST) begin
                    state_n  = RESP;
                    cmd_wr_n = 1'b0;
                    cnt_n    = '0;
                    d_vld_n  = 1'b1;
                    if (!block_write_fM_valid)
                        err_n = 1'b1;
                end
            end
            RESP: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
            default: begin
                state_n  = IDLE;
                cnt_n    = '0;
                cmd_rd_n = 1'b0;
                cmd_wr_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state          <= IDLE;
            cnt            <= '0;
            blk_address_2M <= '0;
            block_write_2M <= '0;
            iBlkData_OUT   <= '0;
            dBlkRData_OUT  <= '0;
            blkRead_2M     <= 1'b0;
            blkWrite_2M    <= 1'b0;
            iBlkValid_OUT  <= 1'b0;
            dBlkValid_OUT  <= 1'b0;
            Busy_OUT       <= 1'b0;
            Err_OUT        <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_d         <= 1'b1;
`endif
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            blk_address_2M <= addr_n;
            block_write_2M <= wdata_n;
            iBlkData_OUT   <= i_data_n;
            dBlkRData_OUT  <= d_data_n;
            blkRead_2M     <= cmd_rd_n;
            blkWrite_2M    <= cmd_wr_n;
            iBlkValid_OUT  <= i_vld_n;
            dBlkValid_OUT  <= d_vld_n;
            Busy_OUT       <= (state_n != IDLE);
            Err_OUT        <= err_n;
`ifdef ARB_ROUND_ROBIN_EN
            last_d         <= last_d_n;
`endif
        end
    end

endmodule

// File: tb/tb_mem_block_arbiter.sv
// tb/tb_mem_block_arbiter.sv - directed self-checking bench for mem_block_arbiter (default build)
module tb_mem_block_arbiter;

    logic         CLK = 1'b0;
    logic         RESET;
    logic         iBlkRead_IN;
    logic [31:0]  iBlkAddr_IN;
    logic [255:0] iBlkData_OUT;
    logic         iBlkValid_OUT;
    logic         dBlkRead_IN;
    logic         dBlkWrite_IN;
    logic [31:0]  dBlkAddr_IN;
    logic [255:0] dBlkWData_IN;
    logic [255:0] dBlkRData_OUT;
    logic         dBlkValid_OUT;
    logic [31:0]  blk_address_2M;
    logic         blkRead_2M;
    logic         blkWrite_2M;
    logic [255:0] block_write_2M;
    logic [255:0] block_read_fM;
    logic         block_read_fM_valid;
    logic         block_write_fM_valid;
    logic         Busy_OUT;
    logic         Err_OUT;

    int tests = 0;
    int fails = 0;

    localparam logic [255:0] D1 = {8{32'hA5A5_0001}};
    localparam logic [255:0] D2 = {8{32'h1234_5678}};
    localparam logic [255:0] D3 = {8{32'hCAFE_0003}};
    localparam logic [255:0] D4 = {8{32'h0BAD_F00D}};
    localparam logic [255:0] WD = {8{32'hDEAD_BEEF}};

    mem_block_arbiter #(.ADDR_W(32), .BLK_W(256), .TIMEOUT(64)) dut (
        .CLK(CLK), .RESET(RESET),
        .iBlkRead_IN(iBlkRead_IN), .iBlkAddr_IN(iBlkAddr_IN),
        .iBlkData_OUT(iBlkData_OUT), .iBlkValid_OUT(iBlkValid_OUT),
        .dBlkRead_IN(dBlkRead_IN), .dBlkWrite_IN(dBlkWrite_IN),
        .dBlkAddr_IN(dBlkAddr_IN), .dBlkWData_IN(dBlkWData_IN),
        .dBlkRData_OUT(dBlkRData_OUT), .dBlkValid_OUT(dBlkValid_OUT),
        .blk_address_2M(blk_address_2M), .blkRead_2M(blkRead_2M),
        .blkWrite_2M(blkWrite_2M), .block_write_2M(block_write_2M),
        .block_read_fM(block_read_fM), .block_read_fM_valid(block_read_fM_valid),
        .block_write_fM_valid(block_write_fM_valid),
        .Busy_OUT(Busy_OUT), .Err_OUT(Err_OUT)
    );

    always #5 CLK = ~CLK;

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        RESET = 1'b1;
        iBlkRead_IN = 1'b0; iBlkAddr_IN = '0;
        dBlkRead_IN = 1'b0; dBlkWrite_IN = 1'b0; dBlkAddr_IN = '0; dBlkWData_IN = '0;
        block_read_fM = '0; block_read_fM_valid = 1'b0; block_write_fM_valid = 1'b0;
        tick(2);
        chk("rst_busy", 256'(Busy_OUT), 256'(0));
        chk("rst_err", 256'(Err_OUT), 256'(0));
        chk("rst_cmds", 256'({blkRead_2M, blkWrite_2M, iBlkValid_OUT, dBlkValid_OUT}), 256'(0));
        chk("rst_addr", 256'(blk_address_2M), 256'(0));
        chk("rst_idata", iBlkData_OUT, 256'(0));
        RESET = 1'b0;
        tick(1);

        // I-side read, memory answers 3 cycles after the command
        iBlkRead_IN = 1'b1; iBlkAddr_IN = 32'h0040_0024;
        tick(1);
        chk("t1_rd_cmd", 256'(blkRead_2M), 256'(1));
        chk("t1_addr", 256'(blk_address_2M), 256'h0040_0020);
        chk("t1_busy", 256'(Busy_OUT), 256'(1));
        tick(2);
        block_read_fM = D1; block_read_fM_valid = 1'b1;
        tick(1);
        chk("t1_ivalid", 256'(iBlkValid_OUT), 256'(1));
        chk("t1_idata", iBlkData_OUT, D1);
        chk("t1_cmd_low", 256'(blkRead_2M), 256'(0));
        block_read_fM_valid = 1'b0; iBlkRead_IN = 1'b0;
        tick(1);
        chk("t1_ivalid_1cyc", 256'(iBlkValid_OUT), 256'(0));
        chk("t1_idle", 256'(Busy_OUT), 256'(0));

        // Three requests at once: write, then D read, then I read
        dBlkWrite_IN = 1'b1; dBlkRead_IN = 1'b1; dBlkAddr_IN = 32'h1000_007F; dBlkWData_IN = WD;
        iBlkRead_IN = 1'b1; iBlkAddr_IN = 32'h2000_0044;
        tick(1);
        chk("t2_wr_cmd", 256'({blkWrite_2M, blkRead_2M}), 256'b10);
        chk("t2_wr_addr", 256'(blk_address_2M), 256'h1000_0060);
        chk("t2_wr_data", block_write_2M, WD);
        block_write_fM_valid = 1'b1;
        tick(1);
        chk("t2_wr_dvalid", 256'({dBlkValid_OUT, iBlkValid_OUT, blkWrite_2M}), 256'b100);
        block_write_fM_valid = 1'b0; dBlkWrite_IN = 1'b0;
        tick(1);
        chk("t2_gap1", 256'({Busy_OUT, dBlkValid_OUT}), 256'b00);
        tick(1);
        chk("t2_rd_cmd", 256'({blkWrite_2M, blkRead_2M}), 256'b01);
        chk("t2_rd_addr", 256'(blk_address_2M), 256'h1000_0060);
        block_read_fM = D2; block_read_fM_valid = 1'b1;
        tick(1);
        chk("t2_rd_dvalid", 256'({dBlkValid_OUT, iBlkValid_OUT}), 256'b10);
        chk("t2_rd_data", dBlkRData_OUT, D2);
        block_read_fM_valid = 1'b0; dBlkRead_IN = 1'b0;
        tick(1);
        chk("t2_gap2", 256'(Busy_OUT), 256'(0));
        tick(1);
        chk("t2_i_addr", 256'({blkRead_2M, blk_address_2M}), {223'(0), 1'b1, 32'h2000_0040});
        // Requester drops its request mid-transaction; completion must still pulse
        iBlkRead_IN = 1'b0;
        tick(1);
        chk("t6_cmd_held", 256'(blkRead_2M), 256'(1));
        block_read_fM = D3; block_read_fM_valid = 1'b1;
        tick(1);
        chk("t6_ivalid", 256'({iBlkValid_OUT, dBlkValid_OUT}), 256'b10);
        chk("t6_idata", iBlkData_OUT, D3);
        block_read_fM_valid = 1'b0;
        tick(1);
        chk("t6_idle", 256'({Busy_OUT, iBlkValid_OUT}), 256'b00);

        // Valid arriving on the final allowed cycle wins over the timeout
        iBlkRead_IN = 1'b1; iBlkAddr_IN = 32'h0000_0100;
        tick(1);
        chk("edge_cmd", 256'(blkRead_2M), 256'(1));
        tick(63);
        chk("edge_cmd_c64", 256'(blkRead_2M), 256'(1));
        block_read_fM = D4; block_read_fM_valid = 1'b1;
        tick(1);
        chk("edge_ivalid", 256'(iBlkValid_OUT), 256'(1));
        chk("edge_idata", iBlkData_OUT, D4);
        chk("edge_no_err", 256'(Err_OUT), 256'(0));
        block_read_fM_valid = 1'b0; iBlkRead_IN = 1'b0;
        tick(1);

        // No memory response: abort after 64 command cycles
        iBlkRead_IN = 1'b1; iBlkAddr_IN = 32'h0000_0200;
        tick(1);
        chk("to_cmd", 256'(blkRead_2M), 256'(1));
        tick(63);
        chk("to_cmd_c64", 256'({blkRead_2M, Err_OUT}), 256'b10);
        tick(1);
        chk("to_cmd_drop", 256'(blkRead_2M), 256'(0));
        chk("to_err", 256'(Err_OUT), 256'(1));
        chk("to_ivalid", 256'(iBlkValid_OUT), 256'(1));
        chk("to_idata", iBlkData_OUT, 256'(0));
        iBlkRead_IN = 1'b0;
        tick(1);
        chk("to_idle", 256'({Busy_OUT, Err_OUT}), 256'b01);
        dBlkRead_IN = 1'b1; dBlkAddr_IN = 32'h0000_0300;
        tick(1);
        chk("post_cmd", 256'(blkRead_2M), 256'(1));
        block_read_fM = D1; block_read_fM_valid = 1'b1;
        tick(1);
        chk("post_dvalid", 256'(dBlkValid_OUT), 256'(1));
        chk("post_ddata", dBlkRData_OUT, D1);
        chk("post_err_sticky", 256'(Err_OUT), 256'(1));
        block_read_fM_valid = 1'b0; dBlkRead_IN = 1'b0;
        tick(2);

        // Wrong-type valid ignored in D_WR, then reset aborts the write
        dBlkWrite_IN = 1'b1; dBlkAddr_IN = 32'h0000_0440; dBlkWData_IN = WD;
        tick(1);
        chk("t5_wr_cmd", 256'(blkWrite_2M), 256'(1));
        block_read_fM_valid = 1'b1;
        tick(1);
        chk("t5_wrong_valid", 256'({blkWrite_2M, dBlkValid_OUT}), 256'b10);
        block_read_fM_valid = 1'b0;
        RESET = 1'b1; dBlkWrite_IN = 1'b0;
        tick(1);
        chk("t5_rst_cmd", 256'({blkWrite_2M, dBlkValid_OUT, Busy_OUT, Err_OUT}), 256'(0));
        chk("t5_rst_addr", 256'(blk_address_2M), 256'(0));
        chk("t5_rst_wdata", block_write_2M, 256'(0));
        RESET = 1'b0;
        tick(2);
        chk("t5_idle", 256'({Busy_OUT, dBlkValid_OUT, blkWrite_2M}), 256'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
